// File: rtl/bfloat_16_div.sv
// Sequential bfloat16 divider: restoring radix-2, one quotient bit per cycle,
// valid/ready on both sides, truncating normalisation with overflow/underflow flags.
module bfloat_16_div #(
    parameter int unsigned BIAS  = 127,
    parameter int unsigned QBITS = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a_sig,
    input  logic [7:0] a_exp,
    input  logic       a_s,
    input  logic [7:0] b_sig,
    input  logic [7:0] b_exp,
    input  logic       b_s,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_sig,
    output logic [7:0] out_exp,
    output logic       out_s,
    output logic       ovf,
    output logic       unf,
    output logic       dbz
);

    typedef enum logic [1:0] {StIdle, StDiv, StNorm, StDone} state_e;

    state_e             state_q, state_d;
    logic [8:0]         r_q;
    logic [QBITS-1:0]   q_q;
    logic [3:0]         cnt_q;
    logic [7:0]         b_sig_q;
    logic [7:0]         a_exp_q;
    logic [7:0]         b_exp_q;

    logic               accept;
    logic               special;
    logic               r_ge;
    logic [8:0]         r_nxt;
    logic signed [9:0]  e_base;
    logic signed [9:0]  e;

    assign accept  = in_valid & in_ready;
    assign special = (b_exp == 8'd0) | (a_exp == 8'd0);

    // Remainder stays below 2*divisor for normalised divisors, so 9 bits suffice.
    always_comb begin
        r_ge  = r_q >= {1'b0, b_sig_q};
        r_nxt = (r_ge ? (r_q - {1'b0, b_sig_q}) : r_q) << 1;
    end

    always_comb begin
        e_base = $signed({2'b00, a_exp_q}) - $signed({2'b00, b_exp_q}) + $signed(10'(BIAS));
        e      = q_q[QBITS-1] ? e_base : e_base - 10'sd1;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = special ? StDone : StDiv;
                end
            end
            StDiv: begin
                if (cnt_q == 4'(QBITS - 1)) begin
                    state_d = StNorm;
                end
            end
            StNorm: state_d = StDone;
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs decode directly from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle:  in_ready  = 1'b1;
            StDone:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            b_sig_q <= '0;
            a_exp_q <= '0;
            b_exp_q <= '0;
            out_sig <= '0;
            out_exp <= '0;
            out_s   <= 1'b0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
            dbz     <= 1'b0;
        end else if (accept) begin
            r_q     <= {1'b0, a_sig};
            q_q     <= '0;
            cnt_q   <= '0;
            b_sig_q <= b_sig;
            a_exp_q <= a_exp;
            b_exp_q <= b_exp;
            out_s   <= a_s ^ b_s;
            ovf     <= 1'b0;
            unf     <= 1'b0;
            dbz     <= 1'b0;
            if (b_exp == 8'd0) begin
                out_sig <= 8'h00;
                out_exp <= 8'hFF;
                dbz     <= 1'b1;
            end else if (a_exp == 8'd0) begin
                out_sig <= 8'h00;
                out_exp <= 8'h00;
            end
        end else if (state_q == StDiv) begin
            q_q   <= {q_q[QBITS-2:0], r_ge};
            r_q   <= r_nxt;
            cnt_q <= cnt_q + 4'd1;
        end else if (state_q == StNorm) begin
            if (e >= 10'sd255) begin
                out_sig <= 8'h00;
                out_exp <= 8'hFF;
                ovf     <= 1'b1;
            end else if (e <= 10'sd0) begin
                out_sig <= 8'h00;
                out_exp <= 8'h00;
                unf     <= 1'b1;
            end else begin
                out_sig <= q_q[QBITS-1] ? q_q[QBITS-1:1] : q_q[QBITS-2:0];
                out_exp <= e[7:0];
            end
        end else if (state_q == StDone && out_ready) begin
            ovf <= 1'b0;
            unf <= 1'b0;
            dbz <= 1'b0;
        end
    end

endmodule
